// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - memory instruction port, instruction handshake and redirect bundle
interface fetch_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output mem_rd, mem_addr, instr, instr_pc, instr_valid,
    input  mem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_rd, mem_addr, instr, instr_pc, instr_valid,
    output mem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC, single outstanding read and redirect
module fetch_unit #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              en,
  output logic [ADDR_W-1:0] pc,
  fetch_if.master           bus
);
  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             transfer;
  logic             issue;
  logic             capture;

  always_comb begin
    transfer = bus.instr_valid & bus.instr_ready & ~bus.redirect;
    issue    = 1'b0;
    capture  = 1'b0;
    state_nx = state;
    case (state)
      FETCH: begin
        if (en && !bus.redirect) begin
          issue    = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) begin
          capture  = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (transfer) begin
          if (en) begin
            issue    = 1'b1;
            state_nx = WAIT;
          end else begin
            state_nx = FETCH;
          end
        end
      end
      default: state_nx = FETCH;
    endcase
    // A redirect or reset abandons whatever read is in flight.
    if (bus.redirect || rst) begin
      issue    = 1'b0;
      capture  = 1'b0;
      state_nx = FETCH;
    end
  end

  assign bus.mem_rd   = issue;
  assign bus.mem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= FETCH;
      pc              <= start_pc;
      cnt             <= '0;
      bus.instr       <= '0;
      bus.instr_pc    <= '0;
      bus.instr_valid <= 1'b0;
    end else begin
      state <= state_nx;
      if (bus.redirect) begin
        pc              <= bus.redirect_pc;
        cnt             <= '0;
        bus.instr_valid <= 1'b0;
      end else begin
        if (issue) begin
          cnt <= CNT_W'(MEM_LAT);
        end else if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end
        if (capture) begin
          bus.instr       <= bus.mem_rdata;
          bus.instr_pc    <= pc;
          pc              <= pc + 1'b1;
          bus.instr_valid <= 1'b1;
        end else if (transfer) begin
          bus.instr_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the multicycle CPU's decode/control logic. It holds the program counter, issues word reads on the instruction port of the dual-port memory, and captures the returned word. It presents each fetched instruction, tagged with its address, through a valid/ready handshake. It also accepts branch redirects from the execute stage, squashing any fetch still in flight.

Parameters:
ADDR_W, 11, width of the PC and memory word address.
DATA_W, 32, instruction width.
MEM_LAT, 2, cycles from the read-issue cycle to valid mem_rdata (≥1; 2 matches registered-address/registered-output RAM).

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start_pc  input  ADDR_W  PC value loaded while rst=1
en  input  1  fetch enable; 0 = issue no new reads
mem_rd  output  1  read strobe to memory instruction port
mem_addr  output  ADDR_W  word address to memory (always = pc)
mem_rdata  input  DATA_W  memory read data
instr  output  DATA_W  captured instruction
instr_pc  output  ADDR_W  address instr was fetched from
instr_valid  output  1  instr/instr_pc valid
instr_ready  input  1  consumer accepts instr this cycle
redirect  input  1  branch taken; flush and load redirect_pc
redirect_pc  input  ADDR_W  new fetch address
pc  output  ADDR_W  current fetch PC (debug/status)

Behaviour:
- Reset:
  - While rst=1: pc<=start_pc, state<=FETCH, lat counter<=0, instr<=0, instr_pc<=0, instr_valid<=0, mem_rd=0.
  - Reset mid-operation discards any in-flight read; data returning afterwards is ignored.
- FETCH state:
  - If en=1 and redirect=0: mem_rd=1, mem_addr=pc, counter<=MEM_LAT, go to WAIT.
  - Otherwise remain in FETCH.
- WAIT state:
  - Counter decrements each cycle.
  - In the cycle counter==1 (issue cycle T + MEM_LAT): instr<=mem_rdata, instr_pc<=pc, pc<=pc+1, instr_valid<=1, go to HOLD.
  - instr_valid therefore first rises in cycle T+MEM_LAT+1.
  - en has no effect on a read already issued.
- HOLD state:
  - instr_valid=1; instr and instr_pc are held stable until the handshake.
  - Transfer occurs when instr_valid & instr_ready & !redirect.
  - On transfer: instr_valid<=0.
    - If en=1, the next read is issued in the same cycle (mem_rd=1, addr=pc, counter<=MEM_LAT, go to WAIT).
    - Else go to FETCH.
  - Best-case throughput: one instruction every MEM_LAT+1 cycles.
- mem_rd is combinational:
  - (state==FETCH & en & !redirect) | (state==HOLD & instr_valid & instr_ready & en & !redirect).
  - mem_addr=pc at all times.
- redirect (priority below rst, above everything else), in any state:
  - pc<=redirect_pc, instr_valid<=0, counter<=0, state<=FETCH.
  - mem_rd=0 in the redirect cycle.
  - An in-flight read's data is never captured.
  - redirect coincident with instr_valid & instr_ready: the transfer does NOT count; the instruction is squashed.
- PC arithmetic: pc+1 is modulo 2^ADDR_W, so 2^ADDR_W-1 wraps to 0.
- instr_pc reports the pre-increment address.
- No more than one read is ever outstanding.

Test Plan:
- Cold start:
  - Stimulus: MEM_LAT=2; memory model returns addr+100; start_pc=0, en=1, instr_ready=1; deassert rst after 3 cycles.
  - Response: mem_rd=1 with addr 0 in the first cycle after reset; instr_valid=1 three cycles later with instr=100, instr_pc=0.
- Streaming:
  - Stimulus: instr_ready held at 1.
  - Response: reads issue every 3 cycles at addr 0,1,2,3; instructions 100,101,102,103 in order, each valid for exactly one cycle.
- Backpressure:
  - Stimulus: instr_ready=0 for 5 cycles while valid.
  - Response: instr/instr_pc stable, mem_rd=0, pc unchanged; in the cycle ready rises, mem_rd=1 at the next address.
- Redirect in WAIT:
  - Stimulus: redirect=1, redirect_pc=0x40, one cycle after an issue to addr 5.
  - Response: data for 5 is never presented; next mem_rd addr=0x40; then instr=0x40+100, instr_pc=0x40.
- Redirect vs handshake collision:
  - Stimulus: valid & ready & redirect(0x10) in the same cycle.
  - Response: instr_valid drops, mem_rd=0 that cycle; next fetch addr=0x10.
- Wrap and reset mid-flight:
  - Stimulus A: start_pc=2047.
  - Response A: instr_pc=2047, next fetch addr=0.
  - Stimulus B: rst asserted during WAIT with start_pc=5.
  - Response B: instr_valid=0; first post-reset fetch addr=5.
  - Stimulus C: en=0 after reset.
  - Response C: mem_rd stays 0.
